// File: rtl/dtw_sram_arb.sv
// dtw_sram_arb: scratch SRAM shared by the DTW core (A) and the host loader (B).
// One grant per cycle. A has priority, and B is forced through after STARVE_MAX denied cycles.

module dtw_sram_rdpipe #(
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    output logic          o_vld,
    output logic [DW-1:0] o_data
);
    logic [LAT:1]         vld_pipe;
    logic [LAT:1][DW-1:0] dat_pipe;

    // A data stage loads only behind a valid, so the last stage keeps the last delivered word.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= i_vld;
            if (i_vld) dat_pipe[1] <= i_data;
            for (int k = 2; k <= LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign o_vld  = vld_pipe[LAT];
    assign o_data = dat_pipe[LAT];
endmodule

module dtw_sram_arb #(
    parameter int DW         = 32,
    parameter int AW         = 10,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            i_a_cs,
    input  logic            i_a_wr,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_be,
    output logic            o_a_gnt,
    output logic [DW-1:0]   o_a_data,
    output logic            o_a_valid,
    input  logic            i_b_cs,
    input  logic            i_b_wr,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_be,
    output logic            o_b_gnt,
    output logic [DW-1:0]   o_b_data,
    output logic            o_b_valid
);
    localparam int NB = DW / 8;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    logic          req_a, req_b, gnt_a, gnt_b, b_forced;
    logic [SW-1:0] starve_cnt;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_be;

    assign req_a    = ~i_a_cs;
    assign req_b    = ~i_b_cs;
    assign b_forced = (starve_cnt == SW'(STARVE_MAX));

    // Reset gates both grants, so the array cannot be written while i_nrst is low.
    assign gnt_b   = i_nrst & req_b & (~req_a | b_forced);
    assign gnt_a   = i_nrst & req_a & ~gnt_b;
    assign o_a_gnt = gnt_a;
    assign o_b_gnt = gnt_b;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)
            starve_cnt <= '0;
        else if (!req_b || gnt_b)
            starve_cnt <= '0;
        else if (!b_forced)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // There is at most one grant, so a single write port serves both requesters.
    assign w_en   = (gnt_a & i_a_wr) | (gnt_b & i_b_wr);
    assign w_addr = gnt_b ? i_b_addr : i_a_addr;
    assign w_data = gnt_b ? i_b_data : i_a_data;
    assign w_be   = gnt_b ? i_b_be   : i_a_be;

    always_ff @(posedge i_clk) begin
        if (w_en)
            for (int i = 0; i < NB; i++)
                if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
    end

    dtw_sram_rdpipe #(.DW(DW), .LAT(RD_LAT)) u_pipe_a (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_vld  (gnt_a & ~i_a_wr),
        .i_data (mem[i_a_addr]),
        .o_vld  (o_a_valid),
        .o_data (o_a_data)
    );

    dtw_sram_rdpipe #(.DW(DW), .LAT(RD_LAT)) u_pipe_b (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_vld  (gnt_b & ~i_b_wr),
        .i_data (mem[i_b_addr]),
        .o_vld  (o_b_valid),
        .o_data (o_b_data)
    );
endmodule

// File: tb/tb_dtw_sram_arb.sv
// Self-checking bench for dtw_sram_arb. Two instances (RD_LAT 1 and 3) share the same stimulus.
// A behavioural model tracks the memory contents, the arbitration rule and the read-return schedule.

module tb_dtw_sram_arb;
    localparam int SM = 4;

    logic clk = 0, nrst = 1;
    always #5 clk = ~clk;

    logic        a_cs = 1, a_wr = 0, b_cs = 1, b_wr = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_data = 0, b_data = 0;
    logic [3:0]  a_be = 0, b_be = 0;

    logic [1:0]       ag, bg, av, bv;
    logic [1:0][31:0] ad, bd;

    dtw_sram_arb #(.RD_LAT(1), .STARVE_MAX(SM)) u_dut0 (
        .i_clk(clk), .i_nrst(nrst),
        .i_a_cs(a_cs), .i_a_wr(a_wr), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_be(a_be),
        .o_a_gnt(ag[0]), .o_a_data(ad[0]), .o_a_valid(av[0]),
        .i_b_cs(b_cs), .i_b_wr(b_wr), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_be(b_be),
        .o_b_gnt(bg[0]), .o_b_data(bd[0]), .o_b_valid(bv[0])
    );

    dtw_sram_arb #(.RD_LAT(3), .STARVE_MAX(SM)) u_dut1 (
        .i_clk(clk), .i_nrst(nrst),
        .i_a_cs(a_cs), .i_a_wr(a_wr), .i_a_addr(a_addr), .i_a_data(a_data), .i_a_be(a_be),
        .o_a_gnt(ag[1]), .o_a_data(ad[1]), .o_a_valid(av[1]),
        .i_b_cs(b_cs), .i_b_wr(b_wr), .i_b_addr(b_addr), .i_b_data(b_data), .i_b_be(b_be),
        .o_b_gnt(bg[1]), .o_b_data(bd[1]), .o_b_valid(bv[1])
    );

    // Behavioural model state.
    logic [31:0] ref_mem [1024];
    logic [63:0] rq [4][$];      // index dut*2+port; each entry is {due edge, data}
    logic [31:0] last [4];
    int          starve = 0, edge_n = 0;
    logic        mga = 0, mgb = 0, dut_gb = 0;
    int          checks = 0, passes = 0, fails = 0;

    function automatic int lat(input int d);
        return (d != 0) ? 3 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            last[i] = 0;
        end
        starve = 0;
    endtask

    task automatic access(input int p, input logic wr, input logic [9:0] addr,
                          input logic [31:0] data, input logic [3:0] be);
        if (wr) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) ref_mem[addr][8*i +: 8] = data[8*i +: 8];
        end else begin
            for (int d = 0; d < 2; d++)
                rq[d*2+p].push_back({32'(edge_n + lat(d) - 1), ref_mem[addr]});
        end
    endtask

    // Run one clock: check grants before the edge, update the model on the edge,
    // then check valid and data on the falling edge.
    task automatic cyc();
        logic ra, rb;
        #1;
        ra = !a_cs;
        rb = !b_cs;
        if (!nrst) begin
            mga = 0;
            mgb = 0;
        end else begin
            mgb = rb && (!ra || starve == SM);
            mga = ra && !mgb;
        end
        dut_gb = bg[0];
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("gnt_a d%0d", d), ag[d], mga);
            chk($sformatf("gnt_b d%0d", d), bg[d], mgb);
        end
        @(posedge clk);
        edge_n++;
        if (nrst) begin
            if (mga) access(0, a_wr, a_addr, a_data, a_be);
            if (mgb) access(1, b_wr, b_addr, b_data, b_be);
            starve = (rb && !mgb) ? ((starve < SM) ? starve + 1 : SM) : 0;
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                logic ev;
                int   qi;
                qi = d*2 + p;
                ev = 0;
                if (rq[qi].size() > 0 && rq[qi][0][63:32] == 32'(edge_n)) begin
                    ev = 1;
                    last[qi] = rq[qi][0][31:0];
                    void'(rq[qi].pop_front());
                end
                chk($sformatf("valid d%0d p%0d", d, p), (p != 0) ? bv[d] : av[d], ev);
                chk($sformatf("data d%0d p%0d", d, p), (p != 0) ? bd[d] : ad[d], last[qi]);
            end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic op(input int p, input logic wr, input logic [9:0] addr,
                      input logic [31:0] data, input logic [3:0] be);
        int n;
        n = 0;
        if (p == 0) begin a_cs = 0; a_wr = wr; a_addr = addr; a_data = data; a_be = be; end
        else        begin b_cs = 0; b_wr = wr; b_addr = addr; b_data = data; b_be = be; end
        do begin
            cyc();
            n++;
        end while (!((p != 0) ? mgb : mga) && n < 20);
        chk("op_grant_timeout", 32'(n < 20 || ((p != 0) ? mgb : mga)), 1);
        if (p == 0) a_cs = 1; else b_cs = 1;
    endtask

    function automatic logic [9:0] raddr();
        return ($urandom_range(16, 0) == 16) ? 10'd1023 : 10'($urandom_range(15, 0));
    endfunction

    initial begin
        // Reset with both ports requesting: no grants, all outputs zero.
        #2;
        nrst = 0;
        model_reset();
        a_cs = 0; a_wr = 0; a_addr = 5;
        b_cs = 0; b_wr = 0; b_addr = 6;
        idle(3);
        nrst = 1;
        a_cs = 1; b_cs = 1;

        // Load the working set through B.
        for (int i = 0; i < 16; i++) op(1, 1, 10'(i), $urandom, 4'hf);
        op(1, 1, 10'd1023, $urandom, 4'hf);
        op(1, 1, 10'd5, 32'h12345678, 4'hf);
        op(0, 0, 10'd5, 0, 0);
        idle(4);
        chk("preload_rd d0", ad[0], 32'h12345678);
        chk("preload_rd d1", ad[1], 32'h12345678);

        // Byte-enable merge.
        op(0, 1, 10'd20, 32'hAABBCCDD, 4'b1111);
        op(0, 1, 10'd20, 32'h11223344, 4'b0101);
        op(0, 1, 10'd20, 32'hFFFFFFFF, 4'b0000);
        op(0, 0, 10'd20, 0, 0);
        idle(4);
        chk("be_merge d0", ad[0], 32'hAA22CC44);
        chk("be_merge d1", ad[1], 32'hAA22CC44);

        // Continuous reads on both ports: grants run A,A,A,A,B.
        a_cs = 0; a_wr = 0; a_addr = 0;
        b_cs = 0; b_wr = 0; b_addr = 8;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("arb_pat %0d", i), dut_gb, (i % 5 == 4));
            if (mga) a_addr = (a_addr + 1) & 10'hf;
            if (mgb) b_addr = (b_addr + 1) & 10'hf;
        end
        a_cs = 1; b_cs = 1;
        idle(4);

        // Burst of eight A reads, one per cycle.
        a_cs = 0; a_wr = 0;
        for (int i = 0; i < 8; i++) begin
            a_addr = 10'(i);
            cyc();
        end
        a_cs = 1;
        idle(5);
        chk("burst_last d1", ad[1], ref_mem[7]);

        // Read-after-write across ports.
        op(1, 1, 10'd1023, 32'hDEADBEEF, 4'hf);
        op(0, 0, 10'd1023, 0, 0);
        idle(4);
        chk("raw d0", ad[0], 32'hDEADBEEF);
        chk("raw d1", ad[1], 32'hDEADBEEF);

        // Reset pulse with a read in flight; a write held during reset must not land.
        op(0, 0, 10'd7, 0, 0);
        nrst = 0;
        model_reset();
        a_cs = 0; a_wr = 1; a_addr = 3; a_data = 32'hBAD0BAD0; a_be = 4'hf;
        b_cs = 0; b_wr = 0; b_addr = 2;
        idle(2);
        a_cs = 1;
        nrst = 1;
        cyc();
        b_cs = 1;
        idle(5);
        op(0, 0, 10'd3, 0, 0);
        op(0, 0, 10'd20, 0, 0);
        idle(4);
        chk("post_reset d0", ad[0], 32'hAA22CC44);

        // Random traffic. Each requester holds its request until it is granted.
        for (int i = 0; i < 400; i++) begin
            if (a_cs || mga) begin
                a_cs = ($urandom_range(3, 0) == 0);
                a_wr = ($urandom_range(2, 0) == 0);
                a_addr = raddr(); a_data = $urandom; a_be = 4'($urandom);
            end
            if (b_cs || mgb) begin
                b_cs = ($urandom_range(3, 0) == 0);
                b_wr = ($urandom_range(2, 0) == 0);
                b_addr = raddr(); b_data = $urandom; b_be = 4'($urandom);
            end
            mga = 0; mgb = 0;
            cyc();
        end
        a_cs = 1; b_cs = 1;
        idle(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
